// File: rtl/unflattening_module.sv
// unflattening_module: rebuilds a registered [F][H][W] feature map from a feature-major flattened stream.
module unflattening_module #(
  parameter int NUM_FEATURES     = 3,
  parameter int HEIGHT           = 12,
  parameter int WIDTH            = 12,
  parameter int FLATTENED_LENGTH = 432,
  parameter int DATA_WIDTH       = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  unflatten_start,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [DATA_WIDTH-1:0]                 unflattened_fmap [NUM_FEATURES][HEIGHT][WIDTH],
  output logic [$clog2(FLATTENED_LENGTH+1)-1:0] elem_count,
  output logic                                  busy,
  output logic                                  unflatten_done
);
  localparam int FW = $clog2(NUM_FEATURES > 1 ? NUM_FEATURES + 1 : 2);
  localparam int RW = $clog2(HEIGHT > 1 ? HEIGHT : 2);
  localparam int CLW = $clog2(WIDTH > 1 ? WIDTH : 2);
  localparam int CW = $clog2(FLATTENED_LENGTH + 1);
  if (FLATTENED_LENGTH != NUM_FEATURES * HEIGHT * WIDTH) begin : g_bad_length
    $error("FLATTENED_LENGTH must equal NUM_FEATURES*HEIGHT*WIDTH");
  end
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t r_state, w_next;
  logic [FW-1:0]  r_feat;
  logic [RW-1:0]  r_row;
  logic [CLW-1:0] r_col;
  logic w_xfer, w_last, w_clear, w_col_end, w_row_end;
  assign w_xfer    = in_valid && in_ready;
  assign w_last    = w_xfer && (elem_count == CW'(FLATTENED_LENGTH - 1));
  assign w_clear   = unflatten_start && (r_state != LOAD);
  assign w_col_end = r_col == CLW'(WIDTH - 1);
  assign w_row_end = r_row == RW'(HEIGHT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == LOAD) ? (w_last ? DONE : LOAD) : (unflatten_start ? LOAD : IDLE);
  always_comb begin
    in_ready       = r_state == LOAD;
    busy           = r_state == LOAD;
    unflatten_done = r_state == DONE;
  end
  // The feature counter may step one past the last map on the final transfer; it is cleared before reuse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_feat     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      elem_count <= '0;
      for (int f = 0; f < NUM_FEATURES; f++)
        for (int r = 0; r < HEIGHT; r++)
          for (int c = 0; c < WIDTH; c++)
            unflattened_fmap[f][r][c] <= '0;
    end else if (w_clear) begin
      r_feat     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      elem_count <= '0;
    end else if (w_xfer) begin
      unflattened_fmap[r_feat][r_row][r_col] <= in_data;
      elem_count <= elem_count + 1'b1;
      r_col      <= w_col_end ? '0 : r_col + 1'b1;
      if (w_col_end) begin
        r_row <= w_row_end ? '0 : r_row + 1'b1;
        if (w_row_end) r_feat <= r_feat + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_unflattening_module.sv
// tb_unflattening_module: randomized directed bench; expected map is the source vector indexed f*H*W + r*W + c.
module tb_unflattening_module;
  localparam int NF = 3, H = 12, W = 12, FL = 432, DW = 8;
  logic clk = 0, reset = 1, unflatten_start = 0, in_valid = 0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, busy, unflatten_done;
  logic [DW-1:0] fmap [NF][H][W];
  logic [$clog2(FL+1)-1:0] elem_count;
  int checks = 0, errors = 0, k = 0;
  logic [DW-1:0] src [FL];
  logic [DW-1:0] orig [NF][H][W];
  unflattening_module #(.NUM_FEATURES(NF), .HEIGHT(H), .WIDTH(W), .FLATTENED_LENGTH(FL), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .unflatten_start(unflatten_start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .unflattened_fmap(fmap), .elem_count(elem_count), .busy(busy),
    .unflatten_done(unflatten_done));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int map_mism(input bit zero);
    int n = 0;
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          if (fmap[f][r][c] !== (zero ? 8'h00 : src[f*H*W + r*W + c])) n++;
    return n;
  endfunction
  function automatic int orig_mism();
    int n = 0;
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          if (fmap[f][r][c] !== orig[f][r][c]) n++;
    return n;
  endfunction
  task automatic fill_index();
    for (int i = 0; i < FL; i++) src[i] = DW'(i % 256);
  endtask
  task automatic fill_round_trip();
    int idx = 0;
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          orig[f][r][c] = DW'($urandom);
          src[idx] = orig[f][r][c];
          idx++;
        end
  endtask
  task automatic start_pulse();
    unflatten_start = 1;
    @(posedge clk);
    @(negedge clk);
    unflatten_start = 0;
    k = 0;
    chk("start_elem_count", elem_count, 0);
    chk("start_busy", busy, 1);
  endtask
  task automatic stream(input int n, input int pct, input int start_at);
    int guard = 0;
    bit v;
    while (k < n && guard < 5000) begin
      chk("in_ready", in_ready, 1);
      chk("busy", busy, 1);
      chk("done_low", unflatten_done, 0);
      chk("elem_count", elem_count, k);
      v = $urandom_range(99) < pct;
      in_valid = v;
      in_data = src[k];
      unflatten_start = (k == start_at);
      @(posedge clk);
      if (v) k++;
      @(negedge clk);
      guard++;
    end
    in_valid = 0;
    unflatten_start = 0;
    chk("stream_len", k, n);
  endtask
  task automatic done_cycle();
    chk("done_pulse", unflatten_done, 1);
    chk("done_in_ready", in_ready, 0);
    chk("done_busy", busy, 0);
    chk("done_elem_count", elem_count, FL);
    chk("done_map", map_mism(0), 0);
  endtask
  task automatic idle_after();
    @(posedge clk);
    @(negedge clk);
    chk("done_once", unflatten_done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_elem_count", elem_count, FL);
    chk("hold_map", map_mism(0), 0);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, unflatten_done, 0);
    chk({tag, "_elem_count"}, elem_count, 0);
    chk({tag, "_map"}, map_mism(1), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 0;
    in_valid = 1;
    in_data = 8'hAA;
    repeat (10) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
    end
    check_zero("idle_ignore");
    start_pulse();
    chk("start_with_valid_no_xfer", fmap[0][0][0], 0);
    fill_index();
    stream(FL, 100, -1);
    done_cycle();
    idle_after();
    start_pulse();
    stream(FL, 50, 100);
    done_cycle();
    idle_after();
    start_pulse();
    stream(200, 70, -1);
    reset = 1;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    reset = 0;
    fill_round_trip();
    start_pulse();
    stream(FL, 80, -1);
    done_cycle();
    chk("round_trip", orig_mism(), 0);
    start_pulse();
    chk("restart_keeps_map", map_mism(0), 0);
    for (int i = 0; i < FL; i++) src[i] = DW'($urandom);
    stream(FL, 60, -1);
    done_cycle();
    idle_after();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
